// File: rtl/alu_mdu.sv
//------------------------------------------------------------------------------
// Module   : alu_mdu
// Brief    : Integer ALU plus iterative RV32M multiply/divide unit behind
//            valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mdu #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      operation,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            flag
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_flag;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_sub;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;

  logic            w_accept;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_flag;
  logic            w_is_mdu;
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flag      = r_flag;
  assign w_shamt   = B[SW-1:0];

  // Single-cycle ALU, compare and undefined opcodes
  always_comb begin
    w_alu_res  = '0;
    w_alu_flag = 1'b0;
    case (operation)
      5'b00000: w_alu_res = A + B;
      5'b01000: w_alu_res = A - B;
      5'b00001: w_alu_res = A << w_shamt;
      5'b00010: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      5'b00011: w_alu_res = {{(XLEN-1){1'b0}}, (A < B)};
      5'b00100: w_alu_res = A ^ B;
      5'b00101: w_alu_res = A >> w_shamt;
      5'b01101: w_alu_res = $signed(A) >>> w_shamt;
      5'b00110: w_alu_res = A | B;
      5'b00111: w_alu_res = A & B;
      5'b11000: w_alu_flag = (A == B);
      5'b11001: w_alu_flag = (A != B);
      5'b11100: w_alu_flag = ($signed(A) < $signed(B));
      5'b11101: w_alu_flag = ($signed(A) >= $signed(B));
      5'b11110: w_alu_flag = (A < B);
      5'b11111: w_alu_flag = (A >= B);
      default:  ;
    endcase
    if (operation[4:3] == 2'b11) begin
      w_alu_res = {{(XLEN-1){1'b0}}, w_alu_flag};
    end
  end

  // The MDU works on magnitudes; signs are re-applied at the final write
  assign w_is_mdu = (operation[4:3] == 2'b10);
  assign w_is_div = operation[2];
  assign w_sa     = (operation[2:0] == 3'b001) || (operation[2:0] == 3'b010) ||
                    (operation[2:0] == 3'b100) || (operation[2:0] == 3'b110);
  assign w_sb     = (operation[2:0] == 3'b001) || (operation[2:0] == 3'b100) ||
                    (operation[2:0] == 3'b110);
  assign w_neg_a  = w_sa && A[XLEN-1];
  assign w_neg_b  = w_sb && B[XLEN-1];
  assign w_mag_a  = w_neg_a ? (~A + 1'b1) : A;
  assign w_mag_b  = w_neg_b ? (~B + 1'b1) : B;

  // Restoring divide step: r_acc is the partial remainder, r_x shifts the
  // dividend out and the quotient in
  logic [XLEN:0]   w_dshift;
  logic [XLEN:0]   w_ddiff;
  logic            w_dok;
  logic [XLEN-1:0] w_div_acc;
  logic [XLEN-1:0] w_div_x;

  assign w_dshift  = {r_acc, r_x[XLEN-1]};
  assign w_ddiff   = w_dshift - {1'b0, r_y};
  assign w_dok     = ~w_ddiff[XLEN];
  assign w_div_acc = w_dok ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0];
  assign w_div_x   = {r_x[XLEN-2:0], w_dok};

  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN-1:0] w_mul_x;

  generate
    if (FAST_MUL) begin : g_mul_fast
      logic [2*XLEN-1:0] w_full;
      assign w_full    = {{XLEN{1'b0}}, r_x} * {{XLEN{1'b0}}, r_y};
      assign w_mul_acc = w_full[2*XLEN-1:XLEN];
      assign w_mul_x   = w_full[XLEN-1:0];
    end else begin : g_mul_iter
      // {r_acc, r_x} is the product register; multiplier bits leave r_x
      logic [XLEN:0] w_msum;
      assign w_msum    = {1'b0, r_acc} + (r_x[0] ? {1'b0, r_y} : {(XLEN+1){1'b0}});
      assign w_mul_acc = w_msum[XLEN:1];
      assign w_mul_x   = {w_msum[0], r_x[XLEN-1:1]};
    end
  endgenerate

  logic [XLEN-1:0]   w_nacc;
  logic [XLEN-1:0]   w_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_mdu_res;

  assign w_nacc     = r_sub[2] ? w_div_acc : w_mul_acc;
  assign w_nx       = r_sub[2] ? w_div_x   : w_mul_x;
  assign w_prod     = {w_nacc, w_nx};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = r_neg_q ? (~w_nx + 1'b1) : w_nx;
  assign w_rem      = r_neg_r ? (~w_nacc + 1'b1) : w_nacc;

  always_comb begin
    w_mdu_res = '0;
    case (r_sub)
      3'b000:                   w_mdu_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   w_mdu_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:           w_mdu_res = w_quo;
      default:                  w_mdu_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_cnt    <= '0;
      r_sub    <= 3'b000;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_is_mdu) begin
              r_sub   <= operation[2:0];
              r_acc   <= '0;
              r_x     <= w_mag_a;
              r_y     <= w_mag_b;
              r_neg_r <= w_neg_a;
              // A zero divisor yields an all-ones quotient with no sign fix
              r_neg_q <= (w_neg_a ^ w_neg_b) && !(w_is_div && (B == '0));
              r_cnt   <= (!w_is_div && FAST_MUL) ? CW'(1) : CW'(XLEN);
              r_state <= S_BUSY;
            end else begin
              r_result <= w_alu_res;
              r_flag   <= w_alu_flag;
              r_state  <= S_DONE;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) begin
            r_result <= w_mdu_res;
            r_flag   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_acc <= w_nacc;
            r_x   <= w_nx;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_mdu
// Brief    : Directed self-checking bench for alu_mdu (XLEN 32 iterative and
//            fast multiply, XLEN 16).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv  [3];
  logic        orr [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        fl  [3];
  logic [4:0]  op  [3];
  logic [31:0] a   [3];
  logic [31:0] b   [3];
  logic [31:0] res0;
  logic [31:0] res1;
  logic [15:0] res2;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] r;
  logic        f;
  int          lat;
  int          seen;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32), .FAST_MUL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .operation(op[0]),
    .A(a[0]), .B(b[0]), .out_valid(ov[0]), .out_ready(orr[0]), .result(res0), .flag(fl[0])
  );

  alu_mdu #(.XLEN(32), .FAST_MUL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .operation(op[1]),
    .A(a[1]), .B(b[1]), .out_valid(ov[1]), .out_ready(orr[1]), .result(res1), .flag(fl[1])
  );

  alu_mdu #(.XLEN(16), .FAST_MUL(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .operation(op[2]),
    .A(a[2][15:0]), .B(b[2][15:0]), .out_valid(ov[2]), .out_ready(orr[2]), .result(res2),
    .flag(fl[2])
  );

  function automatic logic [31:0] rv(input int u);
    case (u)
      0:       rv = res0;
      1:       rv = res1;
      default: rv = {16'h0000, res2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Latency k means out_valid is seen k-1 edges after the transfer edge
  task automatic run(input int u, input logic [4:0] o, input logic [31:0] x,
                     input logic [31:0] y, output logic [31:0] rr, output logic ff,
                     output int ll);
    @(negedge clk);
    iv[u] = 1'b1; op[u] = o; a[u] = x; b[u] = y;
    @(posedge clk);
    #1 iv[u] = 1'b0;
    ll = 1;
    while (!ov[u] && ll < 100) begin
      @(posedge clk);
      #1 ll++;
    end
    rr = rv(u);
    ff = fl[u];
  endtask

  task automatic op_chk(input string tag, input int u, input logic [4:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_lat);
    logic [31:0] rr;
    logic        ff;
    int          ll;
    run(u, o, x, y, rr, ff, ll);
    check(tag, rr, exp);
    check({tag, " lat"}, ll, exp_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; op[i] = 5'd0; a[i] = '0; b[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset in_ready", ir[0], 1);
    check("reset out_valid", ov[0], 0);
    check("reset result", res0, 0);
    check("reset flag", fl[0], 0);

    run(0, 5'b00000, 32'd7, 32'hFFFF_FFFF, r, f, lat);
    check("add result", r, 32'd6);
    check("add flag", f, 0);
    check("add lat", lat, 1);

    // Back-to-back single-cycle ops with no bubble
    @(negedge clk);
    iv[0] = 1'b1; op[0] = 5'b11100; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;
    @(negedge clk);
    check("lts valid", ov[0], 1);
    check("lts result", res0, 32'd1);
    check("lts flag", fl[0], 1);
    op[0] = 5'b11110;
    @(negedge clk);
    check("ltu result", res0, 32'd0);
    check("ltu flag", fl[0], 0);
    op[0] = 5'b01101; a[0] = 32'h8000_0000; b[0] = 32'h24;
    @(negedge clk);
    check("sra result", res0, 32'hF800_0000);
    check("sra flag", fl[0], 0);
    check("sra valid", ov[0], 1);
    iv[0] = 1'b0;

    op_chk("xor", 0, 5'b00100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
    op_chk("undef", 0, 5'b01001, 32'h1234_5678, 32'h1, 32'd0, 1);
    op_chk("sll", 0, 5'b00001, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 1);

    op_chk("div", 0, 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op_chk("rem", 0, 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op_chk("divu by 0", 0, 5'b10101, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
    op_chk("div by 0", 0, 5'b10100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
    op_chk("rem by 0", 0, 5'b10110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33);
    op_chk("div ovf", 0, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    op_chk("rem ovf", 0, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    op_chk("remu", 0, 5'b10111, 32'd100, 32'd7, 32'd2, 33);

    op_chk("mulh", 0, 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op_chk("mulhu", 0, 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    op_chk("mulhsu", 0, 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    op_chk("mul", 0, 5'b10000, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);

    op_chk("fast mulhu", 1, 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    op_chk("fast mulh", 1, 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    op_chk("fast mul", 1, 5'b10000, 32'd7, 32'd6, 32'd42, 2);
    op_chk("fast div", 1, 5'b10101, 32'd100, 32'd7, 32'd14, 33);

    // Backpressure: result must hold while the consumer stalls
    orr[0] = 1'b0;
    run(0, 5'b00000, 32'd1, 32'd2, r, f, lat);
    check("bp add", r, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp hold", res0, 32'd3);
    end
    check("bp in_ready", ir[0], 0);
    check("bp out_valid", ov[0], 1);
    @(negedge clk);
    orr[0] = 1'b1; iv[0] = 1'b1; op[0] = 5'b00000; a[0] = 32'd10; b[0] = 32'd20;
    #1 check("bp release ready", ir[0], 1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    check("bp new valid", ov[0], 1);
    check("bp new result", res0, 32'd30);

    // Reset in the middle of a divide
    @(negedge clk);
    iv[0] = 1'b1; op[0] = 5'b10100; a[0] = 32'd100; b[0] = 32'd3;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort valid", ov[0], 0);
    check("abort result", res0, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (ov[0]) seen++;
    end
    check("abort no output", seen, 0);
    op_chk("after abort", 0, 5'b00000, 32'd2, 32'd2, 32'd4, 1);

    op_chk("x16 divu", 2, 5'b10101, 32'd100, 32'd7, 32'd14, 17);
    op_chk("x16 rem", 2, 5'b10110, 32'h0000_FFF9, 32'd2, 32'h0000_FFFF, 17);
    op_chk("x16 div ovf", 2, 5'b10100, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 17);
    op_chk("x16 sra", 2, 5'b01101, 32'h0000_8000, 32'h0000_0013, 32'h0000_F000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
